// File: rtl/updown_counter_prog.sv
// updown_counter_prog
//   Programmable up/down counter. It has a loadable upper limit, a step size,
//   and three overflow modes: wrap, saturate and one-shot. It also provides a
//   registered terminal-count pulse and a sticky one-shot done flag.
//   It serves as the iteration/bit counter for the shift-add multiplier and
//   for any controller that needs a bounded, self-stopping count.
//
// Ports
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset
//   load     : synchronous load of count and configuration (beats en)
//   en       : count enable (ignored while done = 1)
//   up_down  : 1 = count up, 0 = count down
//   data_in  : count value captured on load (clamped to limit_in)
//   limit_in : upper bound captured on load
//   step_in  : step size captured on load (0 is captured as 1)
//   mode_in  : 00 wrap, 01 saturate, 10 one-shot, 11 same as wrap
//   data_out : current count
//   end_flag : combinational, high when data_out == 0
//   tc_pulse : registered terminal-count / overflow indication
//   done     : sticky one-shot completion flag
module updown_counter_prog #(
  parameter int N      = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  input  logic              up_down,
  input  logic [N-1:0]      data_in,
  input  logic [N-1:0]      limit_in,
  input  logic [STEP_W-1:0] step_in,
  input  logic [1:0]        mode_in,
  output logic [N-1:0]      data_out,
  output logic              end_flag,
  output logic              tc_pulse,
  output logic              done
);

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_WRAP_ALT = 2'b11
  } mode_t;

  logic [N-1:0]      count;
  logic [N-1:0]      limit_r;
  logic [STEP_W-1:0] step_r;
  mode_t             mode_r;
  logic              tc;
  logic              done_r;

  // Next-state datapath, evaluated in N+1 bits so that limit = 2^N-1 with an
  // up step cannot alias back into range.
  logic [N:0]   step_ext;
  logic [N:0]   sum;
  logic         over;
  logic         under;
  logic         saturating;
  logic [N-1:0] nxt;
  logic [N-1:0] term;
  logic         hit;

  always_comb begin
    step_ext   = {{(N+1-STEP_W){1'b0}}, step_r};
    sum        = {1'b0, count} + step_ext;
    over       = sum > {1'b0, limit_r};
    under      = {1'b0, count} < step_ext;
    saturating = (mode_r == MODE_SAT) || (mode_r == MODE_ONESHOT);
    nxt        = count;
    term       = '0;
    hit        = 1'b0;
    if (up_down) begin
      term = limit_r;
      if (over) begin
        nxt = saturating ? limit_r : '0;
      end else begin
        nxt = sum[N-1:0];
      end
      hit = over || (nxt == limit_r);
    end else begin
      term = '0;
      if (under) begin
        nxt = saturating ? '0 : limit_r;
      end else begin
        nxt = count - step_ext[N-1:0];
      end
      hit = under || (nxt == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      limit_r <= '1;
      step_r  <= STEP_W'(1);
      mode_r  <= MODE_WRAP;
      done_r  <= 1'b0;
      tc      <= 1'b0;
    end else if (load) begin
      count   <= (data_in > limit_in) ? limit_in : data_in;
      limit_r <= limit_in;
      step_r  <= (step_in == '0) ? STEP_W'(1) : step_in;
      mode_r  <= mode_t'(mode_in);
      done_r  <= 1'b0;
      tc      <= 1'b0;
    end else if (en && !done_r) begin
      count <= nxt;
      tc    <= hit;
      if ((mode_r == MODE_ONESHOT) && (nxt == term)) begin
        done_r <= 1'b1;
      end
    end else begin
      tc <= 1'b0;
    end
  end

  assign data_out = count;
  assign end_flag = (count == '0);
  assign tc_pulse = tc;
  assign done     = done_r;

endmodule

// File: tb/tb_updown_counter_prog.sv
// tb_updown_counter_prog
//   Self-checking bench for updown_counter_prog (N = 8, STEP_W = 4).
//   It runs directed scenarios and then randomized cycles. All of them are
//   checked against an integer reference model of the counting rules.
module tb_updown_counter_prog;

  localparam int N  = 8;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic          en;
  logic          up_down;
  logic [N-1:0]  data_in;
  logic [N-1:0]  limit_in;
  logic [SW-1:0] step_in;
  logic [1:0]    mode_in;
  logic [N-1:0]  data_out;
  logic          end_flag;
  logic          tc_pulse;
  logic          done;

  updown_counter_prog #(.N(N), .STEP_W(SW)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .en       (en),
    .up_down  (up_down),
    .data_in  (data_in),
    .limit_in (limit_in),
    .step_in  (step_in),
    .mode_in  (mode_in),
    .data_out (data_out),
    .end_flag (end_flag),
    .tc_pulse (tc_pulse),
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state, kept as plain integers
  int m_cnt, m_lim, m_step, m_mode, m_done, m_tc;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".data_out"}, 32'(data_out), m_cnt);
    check_eq({tag, ".end_flag"}, 32'(end_flag), (m_cnt == 0) ? 1 : 0);
    check_eq({tag, ".tc_pulse"}, 32'(tc_pulse), m_tc);
    check_eq({tag, ".done"},     32'(done),     m_done);
  endtask

  function automatic void model_reset();
    m_cnt = 0; m_lim = (1 << N) - 1; m_step = 1; m_mode = 0; m_done = 0; m_tc = 0;
  endfunction

  // One clock edge of the counter, from its rules in plain arithmetic
  function automatic void model_edge();
    int res;
    int hit;
    int wrap;
    if (load) begin
      m_lim  = int'(limit_in);
      m_cnt  = (int'(data_in) > m_lim) ? m_lim : int'(data_in);
      m_step = (step_in == 0) ? 1 : int'(step_in);
      m_mode = int'(mode_in);
      m_done = 0;
      m_tc   = 0;
    end else if (en && m_done == 0) begin
      wrap = (m_mode == 0 || m_mode == 3) ? 1 : 0;
      if (up_down) begin
        if (m_cnt + m_step > m_lim) begin
          res = wrap ? 0 : m_lim;
          hit = 1;
        end else begin
          res = m_cnt + m_step;
          hit = (res == m_lim) ? 1 : 0;
        end
        if (m_mode == 2 && res == m_lim) m_done = 1;
      end else begin
        if (m_cnt < m_step) begin
          res = wrap ? m_lim : 0;
          hit = 1;
        end else begin
          res = m_cnt - m_step;
          hit = (res == 0) ? 1 : 0;
        end
        if (m_mode == 2 && res == 0) m_done = 1;
      end
      m_cnt = res;
      m_tc  = hit;
    end else begin
      m_tc = 0;
    end
  endfunction

  // Drive one cycle's inputs, let the edge happen, then check 1 time unit later
  task automatic cycle(input logic ld, input logic e, input logic ud,
                       input logic [N-1:0] d, input logic [N-1:0] lim,
                       input logic [SW-1:0] st, input logic [1:0] md,
                       input string tag);
    load = ld; en = e; up_down = ud;
    data_in = d; limit_in = lim; step_in = st; mode_in = md;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic step_en(input logic ud, input string tag);
    cycle(1'b0, 1'b1, ud, '0, '0, '0, 2'b00, tag);
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #1;
    rst = 1'b0;
  endtask

  int wrap_exp[3]  = '{8, 0, 3};
  int wrap_tc[3]   = '{0, 1, 0};
  int sat_exp[3]   = '{3, 0, 0};
  int os_exp[6]    = '{4, 8, 10, 10, 10, 10};
  int os_done[6]   = '{0, 0, 1, 1, 1, 1};
  int os_tc[6]     = '{0, 0, 1, 0, 0, 0};
  int fw_exp[3]    = '{255, 0, 1};
  int fw_tc[3]     = '{1, 1, 0};

  initial begin
    rst = 1'b1; load = 1'b0; en = 1'b0; up_down = 1'b1;
    data_in = '0; limit_in = '0; step_in = '0; mode_in = 2'b00;
    model_reset();
    #12;
    check_all("reset");
    rst = 1'b0;

    // Reset configuration: limit all ones, step 1
    step_en(1'b1, "post_reset_up");
    check_eq("post_reset_up.const", 32'(data_out), 1);

    // Reset asserted mid-count at 37
    cycle(1'b1, 1'b0, 1'b1, 8'd30, 8'd100, 4'd7, 2'b00, "rc.load");
    step_en(1'b1, "rc.up");
    check_eq("rc.at37", 32'(data_out), 37);
    async_reset("rc.async");
    check_eq("rc.async.const", 32'(data_out), 0);

    // Wrap up
    cycle(1'b1, 1'b0, 1'b1, 8'd5, 8'd9, 4'd3, 2'b00, "wrap.load");
    for (int i = 0; i < 3; i++) begin
      step_en(1'b1, "wrap.up");
      check_eq("wrap.const_data", 32'(data_out), wrap_exp[i]);
      check_eq("wrap.const_tc", 32'(tc_pulse), wrap_tc[i]);
    end

    // Saturate down
    cycle(1'b1, 1'b0, 1'b1, 8'd7, 8'd20, 4'd4, 2'b01, "sat.load");
    for (int i = 0; i < 3; i++) begin
      step_en(1'b0, "sat.down");
      check_eq("sat.const_data", 32'(data_out), sat_exp[i]);
      check_eq("sat.const_tc", 32'(tc_pulse), (i > 0) ? 1 : 0);
    end

    // One-shot up, then load clears done
    cycle(1'b1, 1'b0, 1'b1, 8'd0, 8'd10, 4'd4, 2'b10, "os.load");
    for (int i = 0; i < 6; i++) begin
      step_en(1'b1, "os.up");
      check_eq("os.const_data", 32'(data_out), os_exp[i]);
      check_eq("os.const_done", 32'(done), os_done[i]);
      check_eq("os.const_tc", 32'(tc_pulse), os_tc[i]);
    end
    cycle(1'b1, 1'b0, 1'b1, 8'd3, 8'd10, 4'd1, 2'b00, "os.reload");
    check_eq("os.reload.const_done", 32'(done), 0);

    // Load clamp, load beats en, step 0 captured as 1
    cycle(1'b1, 1'b1, 1'b1, 8'd200, 8'd50, 4'd0, 2'b00, "clamp.load");
    check_eq("clamp.const_data", 32'(data_out), 50);
    check_eq("clamp.const_tc", 32'(tc_pulse), 0);
    step_en(1'b0, "clamp.step1");
    check_eq("clamp.step1.const", 32'(data_out), 49);

    // Full-width wrap
    cycle(1'b1, 1'b0, 1'b1, 8'd254, 8'd255, 4'd1, 2'b00, "fw.load");
    for (int i = 0; i < 3; i++) begin
      step_en(1'b1, "fw.up");
      check_eq("fw.const_data", 32'(data_out), fw_exp[i]);
      check_eq("fw.const_tc", 32'(tc_pulse), fw_tc[i]);
    end

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] lim;
      if ($urandom_range(0, 79) == 0) begin
        async_reset("rnd.rst");
      end
      lim = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 255))
                                        : N'($urandom_range(0, 24));
      cycle(($urandom_range(0, 11) == 0), ($urandom_range(0, 3) != 0),
            1'($urandom), N'($urandom_range(0, 255)), lim,
            SW'($urandom), 2'($urandom), "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/updown_counter_prog.md
# updown_counter_prog

Parametrised successor to the project's basic N-bit up/down counter. Adds:
- a programmable upper limit;
- a programmable step size;
- three overflow modes: wrap, saturate and one-shot;
- a registered terminal-count pulse and a sticky done flag.

It serves as the iteration and bit counter for the shift-add multiplier datapath and for any controller that needs a bounded, self-stopping count.

## Interface
- N, 8, counter and limit width (N ≥ 2)
- STEP_W, 4, step-size width (STEP_W ≤ N)

- clk  in  1  system clock, rising-edge
- rst  in  1  reset, asynchronous, active-high
- load  in  1  synchronous load of count and configuration
- en  in  1  count enable
- up_down  in  1  direction: 1 = up, 0 = down
- data_in  in  N  count value captured on load
- limit_in  in  N  upper bound captured on load
- step_in  in  STEP_W  step size captured on load
- mode_in  in  2  captured on load: 00 wrap, 01 saturate, 10 one-shot, 11 treated as 00
- data_out  out  N  current count
- end_flag  out  1  combinational, 1 when data_out == 0
- tc_pulse  out  1  registered one-cycle terminal-count pulse
- done  out  1  sticky one-shot completion flag

## Operation
**Registers**
- Registers are count, limit_r, step_r, mode_r, done and tc.
- Configuration is used only from the registered copies. It never changes while counting.

**Load**
- Priority order: rst > load > en > hold.
- On load: count takes data_in, clamped to limit_in if data_in > limit_in.
- Also on load: limit_r, step_r and mode_r are captured, done and tc are cleared.
- A step_in of 0 is captured as 1.

**Counting**
- Arithmetic is unsigned in N+1 bits.
- Terminal value is limit_r when counting up and 0 when counting down.
- Up: nxt = count + step_r. Overflow occurs when nxt > limit_r.
- Down: underflow occurs when count < step_r. Otherwise nxt = count − step_r.
- Wrap (00): up overflow gives 0; down underflow gives limit_r.
- Saturate (01): up overflow gives limit_r; down underflow gives 0.
- One-shot (10): saturates like 01. In the same edge where the count lands on or clamps to the terminal value, done is set.
  - While done = 1, en is ignored and count holds.
  - done clears only on load or rst.

**Terminal-count pulse**
- tc is set on an enabled update whose result equals the terminal value, or that overflowed or underflowed.
- Otherwise tc clears. It also clears when en = 0, when load = 1, and when done was already 1.
- In saturate mode, repeated en at the terminal value keeps tc = 1 every cycle. This "stuck at terminal" indication is intentional.

**Other behaviour**
- up_down may change on any cycle. The terminal value follows the current up_down.
- end_flag tracks count combinationally, regardless of mode.

## Timing
- Reset values:
  - data_out = 0 and end_flag = 1;
  - tc_pulse = 0 and done = 0;
  - limit_r = all ones, step_r = 1, mode_r = 00.
- Latency:
  - load: one edge; data_out is valid in the next cycle.
  - en: one edge per step.
  - tc_pulse and done are asserted in the same cycle that data_out shows the terminal or wrapped value.
- Reset asserted mid-count takes effect immediately (asynchronous), including clearing done and tc. Release is synchronous to the next clk edge; the first update follows that edge.
- load and en in the same cycle: load wins, en is discarded, tc = 0.
- With N = 8, limit = 255 and step = 1, up-wrap 255 → 0 must not be corrupted by N-bit truncation; compare in N+1 bits.

## Test plan
- Reset during count: rst pulse mid-count with count = 37 → data_out = 0, end_flag = 1, tc_pulse = 0, done = 0 immediately, without waiting for clk.
- Wrap up: load data 5, limit 9, step 3, mode 00; en, up for 3 cycles → data_out 8, 0, 3; tc_pulse = 1 only on the cycle showing 0.
- Saturate down: load data 7, limit 20, step 4, mode 01; down for 3 cycles → 3, 0, 0; tc_pulse = 1 on both cycles showing 0; end_flag = 1 from the first 0.
- One-shot up: load data 0, limit 10, step 4, mode 10; en held for 6 cycles → 4, 8, 10, 10, 10, 10; done rises with the first 10 and stays high; tc_pulse high for exactly one cycle; a subsequent load clears done.
- Load clamp and priority: load with data_in = 200, limit_in = 50 and en = 1 in the same cycle → data_out = 50, tc_pulse = 0; step_in = 0 behaves as step 1 on the next en.
- Full-width wrap: N = 8, limit 255, step 1, mode 00; up from 254 → 255 (tc_pulse = 1), then 0 (tc_pulse = 1), then 1 (tc_pulse = 0).
